frontend_read_return: RTL and testbench

Return-path transmitter of the DRAM frontend. It accepts one full read burst per cycle from the backend controller, pairs it in order with the request ID and core ID recorded when the scheduler issued the read, and serializes it to the interconnection. The interconnection sees `BURST_LEN` word beats with a valid/ready handshake and a last marker. It sits between the backend controller return port and the frontend-to-interconnection port, mirroring the scheduler's inbound write-data path.

---
 rtl/frontend_read_return_pkg.sv | 18 +
 rtl/frontend_read_return_if.sv | 61 ++++++
 rtl/frontend_read_return_tag_fifo.sv | 57 +++++
 rtl/frontend_read_return.sv | 105 ++++++++++
 tb/tb_frontend_read_return.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/frontend_read_return_pkg.sv
// Shared types for the DRAM frontend read-return path.
package usertype;

  localparam int unsigned FRONTEND_BURST_LEN = 4;
  localparam int unsigned TAG_ID_W           = 4;
  localparam int unsigned TAG_CORE_ID_W      = 2;

  typedef enum logic [0:0] {
    IDLE,
    SEND
  } read_return_state_t;

  typedef struct packed {
    logic [TAG_ID_W-1:0]      id;
    logic [TAG_CORE_ID_W-1:0] core_id;
  } read_tag_t;

endpackage

// File: rtl/frontend_read_return_if.sv
// Scheduler issue, backend return and interconnection beat signals of the read-return path.
interface frontend_read_return_if #(
  parameter int unsigned WORD_W    = 32,
  parameter int unsigned BURST_LEN = 4,
  parameter int unsigned ID_W      = 4,
  parameter int unsigned CORE_ID_W = 2
);

  logic                        i_read_issue_valid;
  logic [ID_W-1:0]             i_read_issue_id;
  logic [CORE_ID_W-1:0]        i_read_issue_core_id;
  logic                        o_tag_full;
  logic                        o_tag_overflow;
  logic                        o_frontend_receive_ready;
  logic                        i_returned_data_valid;
  logic [WORD_W*BURST_LEN-1:0] i_returned_data;
  logic                        i_interconnection_ready;
  logic                        o_scheduler_request_valid;
  logic [WORD_W-1:0]           o_scheduler_read_data;
  logic                        o_scheduler_read_data_last;
  logic [ID_W-1:0]             o_scheduler_request_ID;
  logic [CORE_ID_W-1:0]        o_scheduler_core_id;
  logic                        o_orphan_error;

  modport slave (
    input  i_read_issue_valid,
    input  i_read_issue_id,
    input  i_read_issue_core_id,
    output o_tag_full,
    output o_tag_overflow,
    output o_frontend_receive_ready,
    input  i_returned_data_valid,
    input  i_returned_data,
    input  i_interconnection_ready,
    output o_scheduler_request_valid,
    output o_scheduler_read_data,
    output o_scheduler_read_data_last,
    output o_scheduler_request_ID,
    output o_scheduler_core_id,
    output o_orphan_error
  );

  modport master (
    output i_read_issue_valid,
    output i_read_issue_id,
    output i_read_issue_core_id,
    input  o_tag_full,
    input  o_tag_overflow,
    input  o_frontend_receive_ready,
    output i_returned_data_valid,
    output i_returned_data,
    output i_interconnection_ready,
    input  o_scheduler_request_valid,
    input  o_scheduler_read_data,
    input  o_scheduler_read_data_last,
    input  o_scheduler_request_ID,
    input  o_scheduler_core_id,
    input  o_orphan_error
  );

endinterface

// File: rtl/frontend_read_return_tag_fifo.sv
// In-order tag FIFO with same-cycle push/pop bypass when empty; DEPTH must be a power of 2 (>= 2).
module read_tag_fifo #(
  parameter int unsigned WIDTH = 6,
  parameter int unsigned DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_pop_data,
  output logic             o_full,
  output logic             o_empty,
  output logic             o_dropped,
  output logic             o_underflow
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [AW:0]      wptr_q, rptr_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             bypass, do_push, do_pop;

  // Pointers carry one extra wrap bit: equal means empty, differing only in MSB means full.
  assign o_empty = (wptr_q == rptr_q);
  assign o_full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);

  assign bypass      = i_push && i_pop && o_empty;
  assign do_push     = i_push && !bypass && (!o_full || i_pop);
  assign do_pop      = i_pop && !o_empty;
  assign o_dropped   = i_push && o_full && !i_pop;
  assign o_underflow = i_pop && o_empty && !i_push;

  always_comb begin
    o_pop_data = '0;
    if (!o_empty) begin
      o_pop_data = mem_q[rptr_q[AW-1:0]];
    end else if (i_push) begin
      o_pop_data = i_push_data;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= i_push_data;
  end

endmodule

// File: rtl/frontend_read_return.sv
// Read-return transmitter: pairs each backend burst with its issue-time tag and serializes it
// to the interconnection as BURST_LEN beats.
module frontend_read_return
  import usertype::*;
#(
  parameter int unsigned WORD_W    = 32,
  parameter int unsigned BURST_LEN = FRONTEND_BURST_LEN,
  parameter int unsigned ID_W      = 4,
  parameter int unsigned CORE_ID_W = 2,
  parameter int unsigned TAG_DEPTH = 4
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  frontend_read_return_if.slave  bus
);

  localparam int unsigned BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int unsigned TAG_W  = ID_W + CORE_ID_W;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);

  read_return_state_t          state_q, state_d;
  logic [BEAT_W-1:0]           beat_q, beat_d;
  logic [WORD_W*BURST_LEN-1:0] burst_q;
  logic [ID_W-1:0]             id_q;
  logic [CORE_ID_W-1:0]        core_q;
  logic                        overflow_q, orphan_q;

  logic             accept;
  logic [TAG_W-1:0] pop_tag;
  logic             fifo_full, fifo_empty, fifo_dropped, fifo_underflow;

  assign accept = (state_q == IDLE) && bus.i_returned_data_valid;

  read_tag_fifo #(
    .WIDTH (TAG_W),
    .DEPTH (TAG_DEPTH)
  ) u_tag_fifo (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_push      (bus.i_read_issue_valid),
    .i_push_data ({bus.i_read_issue_id, bus.i_read_issue_core_id}),
    .i_pop       (accept),
    .o_pop_data  (pop_tag),
    .o_full      (fifo_full),
    .o_empty     (fifo_empty),
    .o_dropped   (fifo_dropped),
    .o_underflow (fifo_underflow)
  );

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = SEND;
          beat_d  = '0;
        end
      end
      SEND: begin
        if (bus.i_interconnection_ready) begin
          if (beat_q == LAST_BEAT) begin
            state_d = IDLE;
            beat_d  = '0;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= IDLE;
      beat_q     <= '0;
      burst_q    <= '0;
      id_q       <= '0;
      core_q     <= '0;
      overflow_q <= 1'b0;
      orphan_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      beat_q     <= beat_d;
      overflow_q <= fifo_dropped;
      orphan_q   <= fifo_underflow;
      if (accept) begin
        burst_q          <= bus.i_returned_data;
        {id_q, core_q}   <= pop_tag;
      end
    end
  end

  assign bus.o_frontend_receive_ready   = (state_q == IDLE);
  assign bus.o_scheduler_request_valid  = (state_q == SEND);
  assign bus.o_scheduler_read_data      = burst_q[beat_q*WORD_W +: WORD_W];
  assign bus.o_scheduler_read_data_last = (state_q == SEND) && (beat_q == LAST_BEAT);
  assign bus.o_scheduler_request_ID     = id_q;
  assign bus.o_scheduler_core_id        = core_q;
  assign bus.o_tag_full                 = fifo_full;
  assign bus.o_tag_overflow             = overflow_q;
  assign bus.o_orphan_error             = orphan_q;

endmodule

// File: tb/tb_frontend_read_return.sv
// Bench for frontend_read_return: directed scenarios plus random traffic against a queue-based
// transaction model of tags and expected beats.
module tb_frontend_read_return;
  import usertype::*;

  localparam int unsigned WORD_W    = 32;
  localparam int unsigned BURST_LEN = 4;
  localparam int unsigned ID_W      = 4;
  localparam int unsigned CORE_ID_W = 2;
  localparam int unsigned TAG_DEPTH = 4;

  typedef struct {
    logic [WORD_W-1:0]    data;
    logic [ID_W-1:0]      id;
    logic [CORE_ID_W-1:0] core;
    logic                 last;
  } beat_t;

  logic i_clk = 1'b0;
  logic i_rst_n;

  frontend_read_return_if #(
    .WORD_W    (WORD_W),
    .BURST_LEN (BURST_LEN),
    .ID_W      (ID_W),
    .CORE_ID_W (CORE_ID_W)
  ) bus ();

  frontend_read_return #(
    .WORD_W    (WORD_W),
    .BURST_LEN (BURST_LEN),
    .ID_W      (ID_W),
    .CORE_ID_W (CORE_ID_W),
    .TAG_DEPTH (TAG_DEPTH)
  ) dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .bus     (bus)
  );

  always #5 i_clk = ~i_clk;

  int        checks = 0;
  int        errors = 0;
  int        hs_count = 0;
  beat_t     exp_q[$];
  read_tag_t tag_q[$];
  logic      ovf_exp = 1'b0;
  logic      orph_exp = 1'b0;

  task automatic chk(input string name, input logic [127:0] obs, input logic [127:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", name, obs, expv);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    tag_q.delete();
    ovf_exp  = 1'b0;
    orph_exp = 1'b0;
  endtask

  // Compare this cycle's outputs to the model, advance the model with this cycle's inputs, clock.
  task automatic cycle();
    logic                        busy, accept, full_before;
    read_tag_t                   tag;
    beat_t                       b;
    logic [WORD_W*BURST_LEN-1:0] burst;
    busy = (exp_q.size() != 0);
    chk("receive_ready", 128'(bus.o_frontend_receive_ready), 128'(!busy));
    chk("request_valid", 128'(bus.o_scheduler_request_valid), 128'(busy));
    chk("tag_full", 128'(bus.o_tag_full), 128'(tag_q.size() == TAG_DEPTH));
    chk("tag_overflow", 128'(bus.o_tag_overflow), 128'(ovf_exp));
    chk("orphan_error", 128'(bus.o_orphan_error), 128'(orph_exp));
    if (busy) begin
      chk("beat_data", 128'(bus.o_scheduler_read_data), 128'(exp_q[0].data));
      chk("beat_id", 128'(bus.o_scheduler_request_ID), 128'(exp_q[0].id));
      chk("beat_core", 128'(bus.o_scheduler_core_id), 128'(exp_q[0].core));
      chk("beat_last", 128'(bus.o_scheduler_read_data_last), 128'(exp_q[0].last));
      if (bus.i_interconnection_ready) begin
        void'(exp_q.pop_front());
        hs_count++;
      end
    end
    accept      = !busy && bus.i_returned_data_valid;
    full_before = (tag_q.size() == TAG_DEPTH);
    ovf_exp     = 1'b0;
    orph_exp    = 1'b0;
    if (accept) begin
      if (tag_q.size() == 0) begin
        if (bus.i_read_issue_valid) begin
          tag.id      = bus.i_read_issue_id;
          tag.core_id = bus.i_read_issue_core_id;
        end else begin
          tag      = '0;
          orph_exp = 1'b1;
        end
      end else begin
        tag = tag_q.pop_front();
        if (bus.i_read_issue_valid) begin
          tag_q.push_back('{id: bus.i_read_issue_id, core_id: bus.i_read_issue_core_id});
        end
      end
      burst = bus.i_returned_data;
      for (int k = 0; k < BURST_LEN; k++) begin
        b.data = burst[k*WORD_W +: WORD_W];
        b.id   = tag.id;
        b.core = tag.core_id;
        b.last = (k == BURST_LEN - 1);
        exp_q.push_back(b);
      end
    end else if (bus.i_read_issue_valid) begin
      if (full_before) ovf_exp = 1'b1;
      else tag_q.push_back('{id: bus.i_read_issue_id, core_id: bus.i_read_issue_core_id});
    end
    @(posedge i_clk);
    #1;
  endtask

  task automatic issue(input int id, input int core);
    bus.i_read_issue_valid   = 1'b1;
    bus.i_read_issue_id      = ID_W'(id);
    bus.i_read_issue_core_id = CORE_ID_W'(core);
    cycle();
    bus.i_read_issue_valid   = 1'b0;
  endtask

  task automatic ret(input logic [WORD_W*BURST_LEN-1:0] data);
    bus.i_returned_data_valid = 1'b1;
    bus.i_returned_data       = data;
    cycle();
    bus.i_returned_data_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) cycle();
    chk("drain_done", 128'(exp_q.size()), 128'(0));
    cycle();
  endtask

  function automatic logic [WORD_W*BURST_LEN-1:0] rand_burst();
    logic [WORD_W*BURST_LEN-1:0] d;
    for (int k = 0; k < BURST_LEN; k++) d[k*WORD_W +: WORD_W] = $urandom;
    return d;
  endfunction

  task automatic check_reset_outputs();
    chk("rst_receive_ready", 128'(bus.o_frontend_receive_ready), 128'(1));
    chk("rst_request_valid", 128'(bus.o_scheduler_request_valid), 128'(0));
    chk("rst_data", 128'(bus.o_scheduler_read_data), 128'(0));
    chk("rst_last", 128'(bus.o_scheduler_read_data_last), 128'(0));
    chk("rst_id", 128'(bus.o_scheduler_request_ID), 128'(0));
    chk("rst_core", 128'(bus.o_scheduler_core_id), 128'(0));
    chk("rst_tag_full", 128'(bus.o_tag_full), 128'(0));
    chk("rst_overflow", 128'(bus.o_tag_overflow), 128'(0));
    chk("rst_orphan", 128'(bus.o_orphan_error), 128'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [WORD_W*BURST_LEN-1:0] dcba;
    dcba = {32'hD, 32'hC, 32'hB, 32'hA};
    i_rst_n                      = 1'b0;
    bus.i_read_issue_valid       = 1'b0;
    bus.i_read_issue_id          = '0;
    bus.i_read_issue_core_id     = '0;
    bus.i_returned_data_valid    = 1'b0;
    bus.i_returned_data          = '0;
    bus.i_interconnection_ready  = 1'b1;
    model_reset();
    #12;
    check_reset_outputs();
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(posedge i_clk);
    #1;

    // Basic burst, ready held high
    issue(3, 1);
    ret(dcba);
    drain();

    // Backpressure: ready low for 2 cycles ahead of beats 1 and 2
    issue(3, 1);
    ret(dcba);
    hs_count = 0;
    bus.i_interconnection_ready = 1'b1; cycle();
    bus.i_interconnection_ready = 1'b0; cycle(); cycle();
    bus.i_interconnection_ready = 1'b1; cycle();
    bus.i_interconnection_ready = 1'b0; cycle(); cycle();
    bus.i_interconnection_ready = 1'b1; cycle();
    cycle();
    chk("backpressure_handshakes", 128'(hs_count), 128'(4));
    drain();

    // Fill the tag FIFO, overflow on the fifth push, then return four bursts in order
    for (int i = 1; i <= 4; i++) issue(i, i % 4);
    chk("fifo_full_after_4", 128'(bus.o_tag_full), 128'(1));
    issue(5, 1);
    chk("overflow_pulse", 128'(bus.o_tag_overflow), 128'(1));
    cycle();
    for (int i = 0; i < 4; i++) begin
      ret(rand_burst());
      drain();
    end

    // Orphan burst: no tag available
    ret(rand_burst());
    chk("orphan_pulse", 128'(bus.o_orphan_error), 128'(1));
    drain();

    // Bypass: issue and return in the same cycle on an empty FIFO, then prove FIFO stayed empty
    bus.i_read_issue_valid   = 1'b1;
    bus.i_read_issue_id      = 4'd7;
    bus.i_read_issue_core_id = 2'd2;
    ret(rand_burst());
    bus.i_read_issue_valid   = 1'b0;
    chk("bypass_id", 128'(bus.o_scheduler_request_ID), 128'(7));
    chk("bypass_no_orphan", 128'(bus.o_orphan_error), 128'(0));
    drain();
    ret(rand_burst());
    drain();

    // Reset after beat 2 of a burst with one tag still queued
    issue(9, 3);
    issue(10, 0);
    ret(rand_burst());
    cycle();
    cycle();
    #2;
    i_rst_n = 1'b0;
    #1;
    model_reset();
    check_reset_outputs();
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(posedge i_clk);
    #1;
    ret(rand_burst());
    drain();
    issue(12, 2);
    ret(rand_burst());
    drain();

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      bus.i_read_issue_valid      = ($urandom_range(0, 2) == 0);
      bus.i_read_issue_id         = ID_W'($urandom);
      bus.i_read_issue_core_id    = CORE_ID_W'($urandom);
      bus.i_returned_data_valid   = ($urandom_range(0, 2) == 0);
      bus.i_returned_data         = rand_burst();
      bus.i_interconnection_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end
    bus.i_read_issue_valid      = 1'b0;
    bus.i_returned_data_valid   = 1'b0;
    bus.i_interconnection_ready = 1'b1;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
